sel_demux4_stream: RTL
======================

// Module: sel_demux4_stream
// PURPOSE
//   Demultiplexer counterpart of the 4:1 sel_code data selector: routes one
//   input stream of DATA_W-bit words to one of four output lanes, chosen per
//   word by a 2-bit sel_code.
//   - Valid/ready handshake on every side; each lane holds one registered slot.
//   - Each lane keeps a saturating delivered-word count.
//   - A flush request stops intake and drains all lanes before acknowledging.
// PARAMETERS
//   DATA_W  8  width of each data word
//   CNT_W   8  width of each per-lane delivered counter (saturating)
// PORTS
//   clk         in   1         single clock, all state on rising edge
//   rst         in   1         asynchronous, active-high reset
//   in_valid    in   1         input word present
//   in_ready    out  1         input word accepted this cycle if in_valid=1
//   in_data     in   DATA_W    input word
//   sel_code    in   2         destination lane for in_data (00->0 .. 11->3)
//   out_valid   out  4         bit i: lane i slot holds a word
//   out_ready   in   4         bit i: lane i consumer takes the word
//   out_data    out  4*DATA_W  lane i word at [i*DATA_W +: DATA_W]
//   out_count   out  4*CNT_W   lane i delivered count at [i*CNT_W +: CNT_W]
//   flush       in   1         level request: stop intake, drain all lanes
//   flush_done  out  1         high while in DONE (all lanes drained)
// BEHAVIOUR
//   Reset: out_valid=0, out_data=0, out_count=0, flush_done=0, state=RUN.
//     Asserting rst mid-transfer discards all slot contents immediately.
//   Intake:
//     - in_ready = (state==RUN) && (!out_valid[sel_code] || out_ready[sel_code]).
//     - in_ready is combinational and independent of in_valid.
//     - sel_code and in_data are don't-care when in_valid=0.
//   Accept (in_valid & in_ready): slot[sel_code] <= in_data and
//     out_valid[sel_code] <= 1 at the next edge. Latency 1 cycle.
//     Other lanes are unaffected.
//   Drain: out_valid[i] & out_ready[i] clears out_valid[i] next edge unless
//     lane i is reloaded that same cycle. out_data holds its last value when
//     not valid.
//   Simultaneous drain and load on the same lane: old word delivered, new word
//     loaded, out_valid[i] stays 1, so one word per cycle per lane is sustained.
//   Lanes drain independently and concurrently; up to 4 deliveries per cycle.
//   Counters: out_count lane i increments on each out_valid[i]&out_ready[i].
//     It saturates at 2^CNT_W-1 (no wrap) and clears only on rst.
//   FSM (RUN, FLUSH, DONE):
//     - RUN: intake enabled. flush=1 -> FLUSH next edge. A word accepted in
//       the same cycle flush is first seen is kept and drained.
//     - FLUSH: in_ready=0; lanes keep draining normally. When out_valid==0,
//       go to DONE next edge (minimum 1 cycle in FLUSH, even if already empty).
//     - DONE: flush_done=1, in_ready=0. flush=0 -> RUN next edge. Stays in
//       DONE while flush stays high.
//     - flush dropped during FLUSH: FLUSH still completes through DONE.
// TESTING
//   1. rst pulse mid-stream with lanes 0,2 full -> all out_valid=0, out_count=0,
//      in_ready=0 until rst low, then in_ready=1.
//   2. Words 0x11,0x22,0x33,0x44 with sel 0,1,2,3, all out_ready=1 -> each lane
//      shows its word 1 cycle after accept; out_count lanes = 1,1,1,1.
//   3. Lane 1 out_ready=0, two words 0xA5,0x5A to sel=01 -> 0xA5 accepted;
//      in_ready=0 for the second word until out_ready[1]=1. Then 0xA5 delivered
//      and 0x5A loaded the same cycle; out_valid[1] stays high.
//   4. CNT_W=2, 5 deliveries on lane 3 -> out_count lane 3 reads 3 and stays 3.
//   5. Lanes 0 and 3 full, out_ready=0, flush=1 -> in_ready drops next cycle.
//      Release out_ready -> flush_done rises 1 cycle after both lanes are empty.
//      Drop flush -> RUN and in_ready=1 next cycle.
//   6. Random valid/ready/sel for 10k cycles vs. per-lane scoreboard queues ->
//      no loss, no duplication, in-order delivery per lane, counts match.

Source files
------------

// File: rtl/sel_demux4_stream.sv
// One-input, four-lane stream demultiplexer. Each word is steered by sel_code into
// a single-entry lane slot. Each lane counts delivered words and saturates, and a flush FSM drains all lanes.
module sel_demux4_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [1:0]            sel_code,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [4*DATA_W-1:0]   out_data,
    output logic [4*CNT_W-1:0]    out_count,
    input  logic                  flush,
    output logic                  flush_done
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_reg;
    logic               flush_done_reg;
    logic [3:0]         valid_reg;
    logic [DATA_W-1:0]  data_reg [4];
    logic [CNT_W-1:0]   cnt_reg  [4];
    logic [3:0]         load;
    logic [3:0]         deliver;
    logic               accept;

    // A lane can take a new word if it is empty or is being emptied this same cycle.
    // The rst term keeps in_ready low for the whole time reset is asserted.
    assign in_ready = !rst && (state_reg == RUN) &&
                      (!valid_reg[sel_code] || out_ready[sel_code]);
    assign accept   = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign load[gi]    = accept && (sel_code == 2'(gi));
            assign deliver[gi] = valid_reg[gi] && out_ready[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                    data_reg[gi]  <= '0;
                    cnt_reg[gi]   <= '0;
                end else begin
                    // A load overrides the clear, so the lane keeps one word per cycle under full throughput.
                    if (load[gi]) begin
                        data_reg[gi]  <= in_data;
                        valid_reg[gi] <= 1'b1;
                    end else if (deliver[gi]) begin
                        valid_reg[gi] <= 1'b0;
                    end
                    if (deliver[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                        cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                    end
                end
            end

            assign out_data[gi*DATA_W +: DATA_W] = data_reg[gi];
            assign out_count[gi*CNT_W +: CNT_W]  = cnt_reg[gi];
        end
    endgenerate

    assign out_valid  = valid_reg;
    assign flush_done = flush_done_reg;

    // The FSM spends at least one cycle in FLUSH. It checks for empty lanes only after the final intake edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= RUN;
            flush_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (flush) begin
                        state_reg <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (valid_reg == 4'b0000) begin
                        state_reg      <= DONE;
                        flush_done_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (!flush) begin
                        state_reg      <= RUN;
                        flush_done_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= RUN;
                    flush_done_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule
